// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD bypassed combinational read ports, two
// prioritised write ports and a per-register busy scoreboard for RAW detection.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic [NUM_REGS-1:0]      busy_vec
);

  logic [DATA_W-1:0]   regs_r [NUM_REGS];
  logic [NUM_REGS-1:0] busy_r;
  logic [ADDR_W-1:0]   ra_s   [NUM_RD];
  logic                we0_ok_s;
  logic                we1_ok_s;
  logic                issue_ok_s;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {{(32-ADDR_W){1'b0}}, a} < 32'(NUM_REGS);
  endfunction

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == {ADDR_W{1'b0}});
  endfunction

  // Qualified enables: reset, out-of-range and hard-wired-zero targets are dropped
  always_comb begin
    we0_ok_s   = we0 && !rst && in_range(wa0) && !is_zero(wa0);
    we1_ok_s   = we1 && !rst && in_range(wa1) && !is_zero(wa1);
    issue_ok_s = issue_en && !rst && in_range(issue_addr) && !is_zero(issue_addr);
  end

  // Register array update; port 1 overrides port 0 on an address collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= {DATA_W{1'b0}};
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we1_ok_s && (wa1 == ADDR_W'(i))) begin
          regs_r[i] <= wd1;
        end else if (we0_ok_s && (wa0 == ADDR_W'(i))) begin
          regs_r[i] <= wd0;
        end
      end
    end
  end

  // Scoreboard: a new issue beats a same-cycle writeback to the same register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= {NUM_REGS{1'b0}};
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (issue_ok_s && (issue_addr == ADDR_W'(i))) begin
          busy_r[i] <= 1'b1;
        end else if ((we1_ok_s && (wa1 == ADDR_W'(i))) || (we0_ok_s && (wa0 == ADDR_W'(i)))) begin
          busy_r[i] <= 1'b0;
        end
      end
    end
  end

  // Split the flat read-address bus into per-port addresses
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) ra_s[k] = rd_addr[k*ADDR_W +: ADDR_W];
  end

  // Read ports with write-to-read bypass and bypass-aware busy
  always_comb begin
    rd_data = {(NUM_RD*DATA_W){1'b0}};
    rd_busy = {NUM_RD{1'b0}};
    for (int k = 0; k < NUM_RD; k++) begin
      if (is_zero(ra_s[k]) || !in_range(ra_s[k]) || rst) begin
        rd_data[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        rd_busy[k] = 1'b0;
      end else if (we1_ok_s && (wa1 == ra_s[k])) begin
        rd_data[k*DATA_W +: DATA_W] = wd1;
        rd_busy[k] = 1'b0;
      end else if (we0_ok_s && (wa0 == ra_s[k])) begin
        rd_data[k*DATA_W +: DATA_W] = wd0;
        rd_busy[k] = 1'b0;
      end else begin
        rd_data[k*DATA_W +: DATA_W] = regs_r[ra_s[k]];
        rd_busy[k] = busy_r[ra_s[k]];
      end
    end
  end

  assign busy_vec = busy_r;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: default build, a ZERO_REG=0 build and a
// NUM_REGS=24 build all driven by the same stimulus.
module tb_reg_file_mp;

  logic        clk;
  logic        rst;
  logic [9:0]  rd_addr;
  logic        we0, we1, issue_en;
  logic [4:0]  wa0, wa1, issue_addr;
  logic [31:0] wd0, wd1;

  logic [63:0] rd_data, rd_data_nz, rd_data_or;
  logic [1:0]  rd_busy, rd_busy_nz, rd_busy_or;
  logic [31:0] busy_vec, busy_vec_nz;
  logic [23:0] busy_vec_or;

  int n_cmp = 0;
  int n_err = 0;

  reg_file_mp dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .issue_en(issue_en), .issue_addr(issue_addr), .busy_vec(busy_vec)
  );

  reg_file_mp #(.ZERO_REG(0)) dut_nz (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nz), .rd_busy(rd_busy_nz),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .issue_en(issue_en), .issue_addr(issue_addr), .busy_vec(busy_vec_nz)
  );

  reg_file_mp #(.NUM_REGS(24)) dut_or (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_or), .rd_busy(rd_busy_or),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .issue_en(issue_en), .issue_addr(issue_addr), .busy_vec(busy_vec_or)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge so inputs change away from it
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; issue_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd_addr = 10'd0; idle();
    wa0 = 5'd0; wa1 = 5'd0; wd0 = 32'd0; wd1 = 32'd0; issue_addr = 5'd0;
    #2;
    chk("reset_rd_data", rd_data, 64'd0);
    chk("reset_busy_vec", {32'd0, busy_vec}, 64'd0);
    #10;
    rst = 1'b0;

    // plain write via port 0, read back on port 1
    tick();
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h1234_5678;
    tick();
    idle(); rd_addr = {5'd3, 5'd0};
    #1;
    chk("wr_rd_r3", {32'd0, rd_data[63:32]}, 64'h1234_5678);
    chk("wr_rd_r3_or", {32'd0, rd_data_or[63:32]}, 64'h1234_5678);

    // same-address dual write: port 1 wins in bypass and in storage
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h1111;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h2222;
    rd_addr = {5'd3, 5'd7};
    #1;
    chk("bypass_prio_r7", {32'd0, rd_data[31:0]}, 64'h2222);
    tick();
    idle();
    #1;
    chk("stored_prio_r7", {32'd0, rd_data[31:0]}, 64'h2222);

    // zero register: dropped with ZERO_REG=1, ordinary with ZERO_REG=0
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF;
    issue_en = 1'b1; issue_addr = 5'd0;
    rd_addr = {5'd3, 5'd0};
    #1;
    chk("zero_no_bypass", {32'd0, rd_data[31:0]}, 64'd0);
    chk("zero_nz_bypass", {32'd0, rd_data_nz[31:0]}, 64'hFFFF_FFFF);
    tick();
    idle();
    #1;
    chk("zero_read", {32'd0, rd_data[31:0]}, 64'd0);
    chk("zero_busy0", {63'd0, busy_vec[0]}, 64'd0);
    chk("zero_rd_busy", {62'd0, rd_busy}, 64'd0);
    chk("zero_nz_stored", {32'd0, rd_data_nz[31:0]}, 64'hFFFF_FFFF);
    chk("zero_nz_busy0", {63'd0, busy_vec_nz[0]}, 64'd1);

    // scoreboard: issue r9, then writeback on port 1
    issue_en = 1'b1; issue_addr = 5'd9; rd_addr = {5'd9, 5'd0};
    #1;
    chk("issue_not_yet", {63'd0, rd_busy[1]}, 64'd0);
    tick();
    idle();
    #1;
    chk("issue_busy_vec9", {63'd0, busy_vec[9]}, 64'd1);
    chk("issue_rd_busy", {63'd0, rd_busy[1]}, 64'd1);
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h0000_ABCD;
    #1;
    chk("wb_rd_busy", {63'd0, rd_busy[1]}, 64'd0);
    chk("wb_bypass", {32'd0, rd_data[63:32]}, 64'hABCD);
    chk("wb_busy_vec_held", {63'd0, busy_vec[9]}, 64'd1);
    tick();
    idle();
    #1;
    chk("wb_busy_vec9", {63'd0, busy_vec[9]}, 64'd0);
    chk("wb_stored", {32'd0, rd_data[63:32]}, 64'hABCD);

    // issue and writeback to the same register in one cycle: busy stays set
    issue_en = 1'b1; issue_addr = 5'd9;
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h55;
    tick();
    idle();
    #1;
    chk("reissue_busy9", {63'd0, busy_vec[9]}, 64'd1);
    chk("reissue_rd_busy", {63'd0, rd_busy[1]}, 64'd1);
    chk("reissue_data", {32'd0, rd_data[63:32]}, 64'h55);

    // out-of-range address on a 24-register file
    we1 = 1'b1; wa1 = 5'd30; wd1 = 32'hCAFE;
    issue_en = 1'b1; issue_addr = 5'd30;
    rd_addr = {5'd9, 5'd30};
    #1;
    chk("oor_bypass_data", {32'd0, rd_data_or[31:0]}, 64'd0);
    chk("oor_bypass_busy", {63'd0, rd_busy_or[0]}, 64'd0);
    chk("inrange_bypass", {32'd0, rd_data[31:0]}, 64'hCAFE);
    tick();
    idle();
    #1;
    chk("oor_read", {32'd0, rd_data_or[31:0]}, 64'd0);
    chk("oor_rd_busy", {63'd0, rd_busy_or[0]}, 64'd0);
    chk("oor_busy_vec", {40'd0, busy_vec_or}, 64'h0000_0200);
    chk("main_busy_vec", {32'd0, busy_vec}, 64'h4000_0200);
    chk("nz_busy_vec", {32'd0, busy_vec_nz}, 64'h4000_0201);

    // asynchronous reset in mid-cycle
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF;
    tick();
    idle(); rd_addr = {5'd9, 5'd5};
    #1;
    chk("r5_written", {32'd0, rd_data[31:0]}, 64'hDEAD_BEEF);
    rst = 1'b1;
    #1;
    chk("async_rst_r5", {32'd0, rd_data[31:0]}, 64'd0);
    chk("async_rst_busy_vec", {32'd0, busy_vec}, 64'd0);
    chk("async_rst_rd_busy", {62'd0, rd_busy}, 64'd0);
    tick();
    rst = 1'b0; rd_addr = {5'd3, 5'd5};
    #1;
    chk("post_rst_r3", {32'd0, rd_data[63:32]}, 64'd0);
    chk("post_rst_r5", {32'd0, rd_data[31:0]}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
